// File: rtl/ls448_bus_sequencer_pkg.sv
// ls448_seq_pkg: shared types and encodings for the sn74ls448 bus sequencer.
//   state_t          : sequencer FSM states
//   SRC_A/SRC_B/SRC_C: bit index of each source in req/gnt/one-hot vectors
//   SEL_*            : transceiver {s1,s0} select encodings
//   sel_of()         : one-hot source -> select encoding
//   gates_of()       : one-hot source + destination mask -> {ga,gb,gc} (active-low)
package ls448_seq_pkg;

    localparam int unsigned NSRC = 3;
    localparam int unsigned DSTW = 2;
    localparam int unsigned SELW = 2;

    localparam int unsigned SRC_A = 2;
    localparam int unsigned SRC_B = 1;
    localparam int unsigned SRC_C = 0;

    localparam logic [SELW-1:0] SEL_A   = 2'b00;
    localparam logic [SELW-1:0] SEL_B   = 2'b01;
    localparam logic [SELW-1:0] SEL_C   = 2'b10;
    localparam logic [SELW-1:0] SEL_OFF = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Select encoding for a one-hot source; an empty source maps to off.
    function automatic logic [SELW-1:0] sel_of(input logic [NSRC-1:0] src_oh);
        logic [SELW-1:0] s;
        s = SEL_OFF;
        if (src_oh[SRC_A])      s = SEL_A;
        else if (src_oh[SRC_B]) s = SEL_B;
        else if (src_oh[SRC_C]) s = SEL_C;
        return s;
    endfunction

    // Destination mask is {first other port, second other port} in A,B,C order.
    // The source's own gate is never enabled.
    function automatic logic [NSRC-1:0] gates_of(input logic [NSRC-1:0] src_oh,
                                                 input logic [DSTW-1:0] mask);
        logic [NSRC-1:0] g;
        g = '1;
        if (src_oh[SRC_A]) begin
            g[SRC_B] = ~mask[1];
            g[SRC_C] = ~mask[0];
        end else if (src_oh[SRC_B]) begin
            g[SRC_A] = ~mask[1];
            g[SRC_C] = ~mask[0];
        end else if (src_oh[SRC_C]) begin
            g[SRC_A] = ~mask[1];
            g[SRC_B] = ~mask[0];
        end
        return g;
    endfunction

endpackage

// File: rtl/ls448_bus_sequencer_if.sv
// ls448_bus_sequencer_if: requester and transceiver-control bundle.
//   req/dst_a/dst_b/dst_c : requests and destination masks (master -> sequencer)
//   gnt/done/err/busy     : transfer status (sequencer -> master)
//   cs/s1/s0/ga/gb/gc     : sn74ls448 control pins (sequencer -> board)
// master: requester side; slave: the sequencer itself.
interface ls448_bus_sequencer_if;
    import ls448_seq_pkg::*;

    logic [NSRC-1:0] req;
    logic [DSTW-1:0] dst_a;
    logic [DSTW-1:0] dst_b;
    logic [DSTW-1:0] dst_c;
    logic [NSRC-1:0] gnt;
    logic            done;
    logic            err;
    logic            busy;
    logic            cs;
    logic            s1;
    logic            s0;
    logic            ga;
    logic            gb;
    logic            gc;

    modport master (
        output req, dst_a, dst_b, dst_c,
        input  gnt, done, err, busy, cs, s1, s0, ga, gb, gc
    );

    modport slave (
        input  req, dst_a, dst_b, dst_c,
        output gnt, done, err, busy, cs, s1, s0, ga, gb, gc
    );

endinterface

// File: rtl/ls448_bus_sequencer_rr_arb3.sv
// rr_arb3: combinational 3-way round-robin arbiter.
//   req  in  3 : requests, bit2=A, bit1=B, bit0=C
//   last in  3 : one-hot of the most recently served source
//   pick out 3 : one-hot winner, zero when no request
// Search order starts at the source after last, cycling A -> B -> C -> A.
module rr_arb3
    import ls448_seq_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] last,
    output logic [NSRC-1:0] pick
);

    always_comb begin
        pick = '0;
        unique case (last)
            3'b100: begin
                if (req[SRC_B])      pick[SRC_B] = 1'b1;
                else if (req[SRC_C]) pick[SRC_C] = 1'b1;
                else if (req[SRC_A]) pick[SRC_A] = 1'b1;
            end
            3'b010: begin
                if (req[SRC_C])      pick[SRC_C] = 1'b1;
                else if (req[SRC_A]) pick[SRC_A] = 1'b1;
                else if (req[SRC_B]) pick[SRC_B] = 1'b1;
            end
            // last = C (reset value) and any corrupt pointer restart at A
            default: begin
                if (req[SRC_A])      pick[SRC_A] = 1'b1;
                else if (req[SRC_B]) pick[SRC_B] = 1'b1;
                else if (req[SRC_C]) pick[SRC_C] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ls448_bus_sequencer.sv
// ls448_bus_sequencer: sole controller of one sn74ls448 tridirectional transceiver.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : ls448_bus_sequencer_if.slave (requests, masks, status, transceiver pins)
// Arbitrates A/B/C round-robin, then runs SETUP -> DRIVE(HOLD) -> RELEASE.
// Every output is a register loaded from the current state, so pins trail the
// state by one cycle and select/gate changes land on separate edges.
module ls448_bus_sequencer
    import ls448_seq_pkg::*;
#(
    parameter int unsigned HOLD = 2,
    parameter int unsigned CW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ls448_bus_sequencer_if.slave bus
);

    state_t          state, state_d;
    logic [NSRC-1:0] last_q, last_d;
    logic [NSRC-1:0] src_q, src_d;
    logic [DSTW-1:0] mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NSRC-1:0] pick;
    logic [DSTW-1:0] pick_mask;

    logic            cs_q, cs_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NSRC-1:0] g_q, g_d;
    logic [NSRC-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    rr_arb3 u_arb (
        .req  (bus.req),
        .last (last_q),
        .pick (pick)
    );

    // Destination mask belonging to the arbitration winner.
    always_comb begin
        pick_mask = '0;
        if (pick[SRC_A])      pick_mask = bus.dst_a;
        else if (pick[SRC_B]) pick_mask = bus.dst_b;
        else if (pick[SRC_C]) pick_mask = bus.dst_c;
    end

    // State, latches, pointer and output-register next values.
    always_comb begin
        state_d = state;
        last_d  = last_q;
        src_d   = src_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b1;
        sel_d   = SEL_OFF;
        g_d     = '1;
        gnt_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b1;

        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (pick != '0) begin
                    if (pick_mask == '0) begin
                        // nothing to drive: report and skip past this source
                        err_d  = 1'b1;
                        last_d = pick;
                    end else begin
                        src_d   = pick;
                        mask_d  = pick_mask;
                        cnt_d   = '0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cs_d    = 1'b0;
                sel_d   = sel_of(src_q);
                gnt_d   = src_q;
                state_d = DRIVE;
            end
            DRIVE: begin
                cs_d  = 1'b0;
                sel_d = sel_of(src_q);
                gnt_d = src_q;
                g_d   = gates_of(src_q, mask_q);
                if (cnt_q == CW'(HOLD - 1)) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                cs_d    = 1'b0;
                sel_d   = sel_of(src_q);
                gnt_d   = src_q;
                done_d  = 1'b1;
                last_d  = src_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; last = C so A wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_q <= 3'b001;
            src_q  <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_d;
            last_q <= last_d;
            src_q  <= src_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= 1'b1;
            sel_q  <= SEL_OFF;
            g_q    <= '1;
            gnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cs_q   <= cs_d;
            sel_q  <= sel_d;
            g_q    <= g_d;
            gnt_q  <= gnt_d;
            done_q <= done_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    assign bus.cs   = cs_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.ga   = g_q[SRC_A];
    assign bus.gb   = g_q[SRC_B];
    assign bus.gc   = g_q[SRC_C];
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;

endmodule
